// File: rtl/cache_miss_ctrl.sv
// rtl/cache_miss_ctrl.sv - data cache miss sequencer (write-back, refill, respond); optional PERF_CNT_EN counters
module cache_miss_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int BLOCK_OFFSET = 4,
    parameter int MEM_LATENCY  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic                  hit,
    input  logic                  dirty,
    input  logic [DATA_WIDTH-1:0] victim_addr,
    output logic                  stall,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic                  refill_en,
    output logic                  busy,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
    output logic [31:0]           wb_count
);

    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        RESPOND   = 2'd3
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_next;
    logic [DATA_WIDTH-1:0] miss_blk;
    logic [DATA_WIDTH-1:0] victim_blk;
    logic                  miss;

    // Offset bits of both addresses are dropped on purpose: memory moves whole blocks.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{req_addr[BLOCK_OFFSET-1:0], victim_addr[BLOCK_OFFSET-1:0]};

    assign miss = (state == IDLE) && req_valid && !hit;

    // State, latency counter and latched block addresses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            miss_blk   <= '0;
            victim_blk <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            if (miss) begin
                miss_blk   <= {req_addr[DATA_WIDTH-1:BLOCK_OFFSET], {BLOCK_OFFSET{1'b0}}};
                victim_blk <= {victim_addr[DATA_WIDTH-1:BLOCK_OFFSET], {BLOCK_OFFSET{1'b0}}};
            end
        end
    end

    // Next state and counter; each transfer state counts MEM_LATENCY-1 down to 0.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (miss) begin
                    next_state = dirty ? WRITEBACK : REFILL;
                    cnt_next   = CNT_LOAD;
                end
            end
            WRITEBACK: begin
                if (cnt == '0) begin
                    next_state = REFILL;
                    cnt_next   = CNT_LOAD;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            REFILL: begin
                if (cnt == '0) begin
                    next_state = RESPOND;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs; the IDLE stall is combinational so the missing access freezes in its own cycle.
    always_comb begin
        stall     = 1'b0;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        refill_en = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:      stall = req_valid && !hit && !rst;
            WRITEBACK: begin
                stall     = 1'b1;
                mem_wr_en = 1'b1;
                mem_addr  = victim_blk;
            end
            REFILL: begin
                stall     = 1'b1;
                mem_rd_en = 1'b1;
                mem_addr  = miss_blk;
                refill_en = (cnt == '0);
            end
            default: ;
        endcase
    end

`ifdef PERF_CNT_EN
    // Performance counters: only IDLE-state lookups count, so the RESPOND retry is excluded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else if (state == IDLE && req_valid) begin
            if (hit) begin
                hit_count <= hit_count + 32'd1;
            end else begin
                miss_count <= miss_count + 32'd1;
                if (dirty) begin
                    wb_count <= wb_count + 32'd1;
                end
            end
        end
    end
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
    assign wb_count   = 32'd0;
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb/tb_cache_miss_ctrl.sv - self-checking bench for cache_miss_ctrl with a phase-based reference model
module tb_cache_miss_ctrl;

    localparam int LAT = 3;
    localparam logic [31:0] BLK_MASK = ~((32'd1 << 4) - 32'd1);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        hit = 1'b0;
    logic        dirty = 1'b0;
    logic [31:0] victim_addr = '0;
    logic        stall, mem_wr_en, mem_rd_en, refill_en, busy;
    logic [31:0] mem_addr, hit_count, miss_count, wb_count;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    cache_miss_ctrl #(.DATA_WIDTH(32), .BLOCK_OFFSET(4), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .hit(hit),
        .dirty(dirty), .victim_addr(victim_addr), .stall(stall), .mem_wr_en(mem_wr_en),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .refill_en(refill_en), .busy(busy),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef PERF_CNT_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    // Reference model: a miss opens a transaction; its phase number alone defines the outputs.
    int          m_phase = -1;
    bit          m_dirty;
    logic [31:0] m_blk, m_vic;
    logic [31:0] m_hits = 0, m_miss = 0, m_wbs = 0;

    always @(negedge clk) begin
        if (check_en) begin
            logic e_stall, e_wr, e_rd, e_ref, e_busy;
            logic [31:0] e_addr;
            int wb_len;
            e_stall = 0; e_wr = 0; e_rd = 0; e_ref = 0; e_busy = 0; e_addr = 0;
            if (rst) begin
                m_phase = -1; m_hits = 0; m_miss = 0; m_wbs = 0;
            end else if (m_phase < 0) begin
                e_stall = req_valid && !hit;
            end else begin
                e_busy = 1;
                wb_len = m_dirty ? LAT : 0;
                if (m_phase <= wb_len) begin
                    e_stall = 1; e_wr = 1; e_addr = m_vic;
                end else if (m_phase <= wb_len + LAT) begin
                    e_stall = 1; e_rd = 1; e_addr = m_blk;
                    e_ref = (m_phase == wb_len + LAT);
                end
            end
            cmp("stall", {31'd0, stall}, {31'd0, e_stall});
            cmp("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, e_wr});
            cmp("mem_rd_en", {31'd0, mem_rd_en}, {31'd0, e_rd});
            cmp("refill_en", {31'd0, refill_en}, {31'd0, e_ref});
            cmp("busy", {31'd0, busy}, {31'd0, e_busy});
            cmp("mem_addr", mem_addr, e_addr);
            cmp("hit_count", hit_count, exp_cnt(m_hits));
            cmp("miss_count", miss_count, exp_cnt(m_miss));
            cmp("wb_count", wb_count, exp_cnt(m_wbs));
            if (!rst) begin
                if (m_phase < 0) begin
                    if (req_valid && hit) begin
                        m_hits++;
                    end else if (req_valid) begin
                        m_miss++;
                        if (dirty) m_wbs++;
                        m_dirty = dirty;
                        m_blk   = req_addr & BLK_MASK;
                        m_vic   = victim_addr & BLK_MASK;
                        m_phase = 1;
                    end
                end else begin
                    m_phase++;
                    if (m_phase > (m_dirty ? 2 * LAT : LAT) + 1) m_phase = -1;
                end
            end
        end
    end

    logic        s_stall, s_wr, s_rd, s_ref;
    logic [31:0] s_addr;

    // One cycle: drive inputs, sample outputs at the falling edge, return just after the rising edge.
    task automatic step(input logic v, input logic h, input logic d,
                        input logic [31:0] a, input logic [31:0] va);
        req_valid = v; hit = h; dirty = d; req_addr = a; victim_addr = va;
        @(negedge clk);
        s_stall = stall; s_wr = mem_wr_en; s_rd = mem_rd_en; s_ref = refill_en; s_addr = mem_addr;
        @(posedge clk);
        #1;
    endtask

    task automatic step_rand();
        step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom);
    endtask

    initial begin
        int st, wr, rd, rf, rfc, rfc2, bad;
        #1 rst = 1'b1;
        #1;
        cmp("reset_busy", {31'd0, busy}, 32'd0);
        cmp("reset_miss_count", miss_count, 32'd0);
        check_en = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
        step(0, 0, 0, 0, 0);

        // Four hits: no stall, no strobes.
        st = 0; wr = 0;
        for (int c = 0; c < 4; c++) begin
            step(1, 1, 0, 32'h100, 0);
            st += int'(s_stall);
            wr += int'(s_wr) + int'(s_rd) + int'(s_ref);
        end
        cmp("hit_stall_cycles", st, 0);
        cmp("hit_strobes", wr, 0);
        cmp("hit_count_4", hit_count, exp_cnt(32'd4));
        step(0, 0, 0, 0, 0);

        // Clean miss at 0x1234; inputs wander while the pipeline is frozen.
        st = 0; rd = 0; rf = 0; rfc = 0; bad = 0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 1)      step(1, 0, 0, 32'h1234, 32'h9990);
            else if (c <= 4) step_rand();
            else if (c == 5) step(1, 1, 0, 32'h1234, 0);
            else             step(0, 0, 0, 0, 0);
            st += int'(s_stall);
            if (s_rd) begin rd++; if (s_addr !== 32'h1230) bad++; end
            if (s_ref) begin rf++; rfc = c; end
            if (c == 5) cmp("clean_stall_c5", {31'd0, s_stall}, 32'd0);
        end
        cmp("clean_stall_cycles", st, 4);
        cmp("clean_rd_cycles", rd, 3);
        cmp("clean_rd_addr_bad", bad, 0);
        cmp("clean_refill_pulses", rf, 1);
        cmp("clean_refill_cycle", rfc, 4);
        cmp("clean_miss_count", miss_count, exp_cnt(32'd1));
        cmp("clean_hit_count", hit_count, exp_cnt(32'd4));

        // Dirty miss at 0x2008 with victim 0x5000.
        st = 0; wr = 0; rd = 0; bad = 0;
        for (int c = 1; c <= 9; c++) begin
            if (c == 1)      step(1, 0, 1, 32'h2008, 32'h5000);
            else if (c <= 7) step_rand();
            else if (c == 8) step(1, 1, 0, 32'h2008, 0);
            else             step(0, 0, 0, 0, 0);
            st += int'(s_stall);
            if (s_wr) begin wr++; if (s_addr !== 32'h5000) bad++; end
            if (s_rd) begin rd++; if (s_addr !== 32'h2000) bad++; end
            if (s_wr && s_rd) bad++;
        end
        cmp("dirty_stall_cycles", st, 7);
        cmp("dirty_wr_cycles", wr, 3);
        cmp("dirty_rd_cycles", rd, 3);
        cmp("dirty_addr_bad", bad, 0);
        cmp("dirty_wb_count", wb_count, exp_cnt(32'd1));
        cmp("dirty_miss_count", miss_count, exp_cnt(32'd2));

        // Reset during the last REFILL cycle.
        step(1, 0, 0, 32'h3000, 0);
        step_rand();
        step_rand();
        req_valid = 0;
        cmp("pre_rst_rd", {31'd0, mem_rd_en}, 32'd1);
        cmp("pre_rst_refill", {31'd0, refill_en}, 32'd1);
        rst = 1'b1;
        #1;
        cmp("rst_stall", {31'd0, stall}, 32'd0);
        cmp("rst_rd", {31'd0, mem_rd_en}, 32'd0);
        cmp("rst_refill", {31'd0, refill_en}, 32'd0);
        cmp("rst_busy", {31'd0, busy}, 32'd0);
        cmp("rst_addr", mem_addr, 32'd0);
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
        step(0, 0, 0, 0, 0);
        cmp("rst_miss_count", miss_count, 32'd0);

        // Back-to-back misses: the second is only seen after RESPOND.
        rf = 0; rfc = 0; rfc2 = 0;
        for (int c = 1; c <= 12; c++) begin
            if (c == 1)      step(1, 0, 0, 32'h40, 0);
            else if (c <= 6) step(1, 0, 0, 32'h80, 0);
            else             step(0, 0, 0, 0, 0);
            if (s_ref) begin rf++; if (rf == 1) rfc = c; else rfc2 = c; end
            if (c == 5) cmp("b2b_stall_c5", {31'd0, s_stall}, 32'd0);
            if (c == 7) cmp("b2b_addr_c7", s_addr, 32'h80);
        end
        cmp("b2b_refill_pulses", rf, 2);
        cmp("b2b_refill_first", rfc, 4);
        cmp("b2b_refill_second", rfc2, 9);
        cmp("b2b_miss_count", miss_count, exp_cnt(32'd2));

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                step(0, 0, 0, 0, 0);
                rst = 1'b0;
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                     $urandom, $urandom);
            end
        end

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
